// File: rtl/adder_reservation_stations.sv
// rtl/adder_reservation_stations.sv - adder reservation stations with register renaming, pipelined adder and result bus
module adder_reservation_stations #(
  parameter int NUM_RS        = 3,
  parameter int ADDER_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue,
  input  logic [5:0]  operation,
  input  logic [2:0]  execution_unit,
  input  logic [4:0]  Dest_address,
  input  logic [4:0]  A_address,
  input  logic [4:0]  B_address,
  output logic        issue_error,
  output logic        adder_available,
  output logic [5:0]  adder_RS_available,
  output logic [5:0]  RS_issued,
  output logic [5:0]  RS_executing_adder,
  output logic [5:0]  RS_finished,
  output logic        adder_rts,
  output logic [31:0] result_value,
  output logic [4:0]  result_dest
);

  // A latency below one would leave no pipeline stage to hold the dispatched op.
  localparam int LAT = (ADDER_LATENCY < 1) ? 1 : ADDER_LATENCY;

  // Architectural register file and register-status (rename) table.
  logic [31:0] r_regs   [32];
  logic [5:0]  r_status [32];

  // Station fields; station index i carries tag i+1.
  logic        r_busy [NUM_RS];
  logic        r_exec [NUM_RS];
  logic [2:0]  r_func [NUM_RS];
  logic [4:0]  r_dest [NUM_RS];
  logic [31:0] r_vj   [NUM_RS];
  logic [5:0]  r_qj   [NUM_RS];
  logic [31:0] r_vk   [NUM_RS];
  logic [5:0]  r_qk   [NUM_RS];

  // Adder pipeline: stage 0 is loaded on dispatch, stage LAT is the result bus.
  logic        r_pv    [LAT+1];
  logic [5:0]  r_ptag  [LAT+1];
  logic [4:0]  r_pdest [LAT+1];
  logic [31:0] r_pval  [LAT+1];

  // Registered one-cycle pulses.
  logic        r_issue_error;
  logic [5:0]  r_rs_issued;
  logic [5:0]  r_rs_exec;

  logic        w_free_found;
  logic [5:0]  w_free_tag;
  logic        w_disp_found;
  logic [5:0]  w_disp_tag;
  logic [2:0]  w_disp_func;
  logic [4:0]  w_disp_dest;
  logic [31:0] w_disp_vj;
  logic [31:0] w_disp_vk;
  logic        w_issue_ok;
  logic        w_issue_err;
  logic        w_bc_valid;
  logic [5:0]  w_bc_tag;
  logic [4:0]  w_bc_dest;
  logic [31:0] w_bc_value;
  logic [5:0]  w_stat_a;
  logic [5:0]  w_stat_b;
  logic [31:0] w_cap_vj;
  logic [5:0]  w_cap_qj;
  logic [31:0] w_cap_vk;
  logic [5:0]  w_cap_qk;
  logic        w_unused_op;

  // Only the low three opcode bits select the ALU function.
  assign w_unused_op = ^operation[5:3];

  function automatic logic [31:0] f_alu(input logic [2:0] func, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] res;
    case (func)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b100:  res = a | b;
      3'b101:  res = a & b;
      3'b110:  res = ~a;
      3'b111:  res = a ^ b;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // The last pipeline stage is the result bus seen by stations and the register file.
  assign w_bc_valid = r_pv[LAT];
  assign w_bc_tag   = r_ptag[LAT];
  assign w_bc_dest  = r_pdest[LAT];
  assign w_bc_value = r_pval[LAT];

  // Lowest-index free station, from current state only (a station freed on this edge is offered next cycle).
  always_comb begin
    w_free_found = 1'b0;
    w_free_tag   = 6'd0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!w_free_found && !r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_tag   = 6'(i + 1);
      end
    end
  end

  // Lowest-index station with both operands ready and not yet dispatched.
  always_comb begin
    w_disp_found = 1'b0;
    w_disp_tag   = 6'd0;
    w_disp_func  = 3'd0;
    w_disp_dest  = 5'd0;
    w_disp_vj    = 32'd0;
    w_disp_vk    = 32'd0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!w_disp_found && r_busy[i] && !r_exec[i] && r_qj[i] == 6'd0 && r_qk[i] == 6'd0) begin
        w_disp_found = 1'b1;
        w_disp_tag   = 6'(i + 1);
        w_disp_func  = r_func[i];
        w_disp_dest  = r_dest[i];
        w_disp_vj    = r_vj[i];
        w_disp_vk    = r_vk[i];
      end
    end
  end

  assign w_issue_ok  = issue && (execution_unit == 3'b000) && w_free_found;
  assign w_issue_err = issue && !w_issue_ok;

  // Operand capture at issue: register value, forwarded broadcast, or producer tag.
  always_comb begin
    w_stat_a = r_status[A_address];
    w_stat_b = r_status[B_address];
    w_cap_vj = 32'd0;
    w_cap_qj = w_stat_a;
    w_cap_vk = 32'd0;
    w_cap_qk = w_stat_b;
    if (w_stat_a == 6'd0) begin
      w_cap_vj = r_regs[A_address];
    end else if (w_bc_valid && w_bc_tag == w_stat_a) begin
      w_cap_vj = w_bc_value;
      w_cap_qj = 6'd0;
    end
    if (w_stat_b == 6'd0) begin
      w_cap_vk = r_regs[B_address];
    end else if (w_bc_valid && w_bc_tag == w_stat_b) begin
      w_cap_vk = w_bc_value;
      w_cap_qk = 6'd0;
    end
  end

  // Register file write-back and rename table; a new issue to the same register overrides the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i]   <= 32'(i);
        r_status[i] <= 6'd0;
      end
    end else begin
      if (w_bc_valid) begin
        r_regs[w_bc_dest] <= w_bc_value;
        if (r_status[w_bc_dest] == w_bc_tag) begin
          r_status[w_bc_dest] <= 6'd0;
        end
      end
      if (w_issue_ok) begin
        r_status[Dest_address] <= w_free_tag;
      end
    end
  end

  // Station lifecycle: allocate on issue, resolve tags from the bus, mark dispatch, free on completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) begin
        r_busy[i] <= 1'b0;
        r_exec[i] <= 1'b0;
        r_func[i] <= 3'd0;
        r_dest[i] <= 5'd0;
        r_vj[i]   <= 32'd0;
        r_qj[i]   <= 6'd0;
        r_vk[i]   <= 32'd0;
        r_qk[i]   <= 6'd0;
      end
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (w_bc_valid && w_bc_tag == 6'(i + 1)) begin
          r_busy[i] <= 1'b0;
          r_exec[i] <= 1'b0;
        end else if (r_busy[i]) begin
          if (w_bc_valid && r_qj[i] == w_bc_tag) begin
            r_vj[i] <= w_bc_value;
            r_qj[i] <= 6'd0;
          end
          if (w_bc_valid && r_qk[i] == w_bc_tag) begin
            r_vk[i] <= w_bc_value;
            r_qk[i] <= 6'd0;
          end
          if (w_disp_found && w_disp_tag == 6'(i + 1)) begin
            r_exec[i] <= 1'b1;
          end
        end else if (w_issue_ok && w_free_tag == 6'(i + 1)) begin
          r_busy[i] <= 1'b1;
          r_exec[i] <= 1'b0;
          r_func[i] <= operation[2:0];
          r_dest[i] <= Dest_address;
          r_vj[i]   <= w_cap_vj;
          r_qj[i]   <= w_cap_qj;
          r_vk[i]   <= w_cap_vk;
          r_qk[i]   <= w_cap_qk;
        end
      end
    end
  end

  // Fully pipelined adder: compute on dispatch, then shift toward the result bus; idle slots carry zeros.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j <= LAT; j++) begin
        r_pv[j]    <= 1'b0;
        r_ptag[j]  <= 6'd0;
        r_pdest[j] <= 5'd0;
        r_pval[j]  <= 32'd0;
      end
    end else begin
      r_pv[0]    <= w_disp_found;
      r_ptag[0]  <= w_disp_found ? w_disp_tag : 6'd0;
      r_pdest[0] <= w_disp_found ? w_disp_dest : 5'd0;
      r_pval[0]  <= w_disp_found ? f_alu(w_disp_func, w_disp_vj, w_disp_vk) : 32'd0;
      for (int j = 1; j <= LAT; j++) begin
        r_pv[j]    <= r_pv[j-1];
        r_ptag[j]  <= r_ptag[j-1];
        r_pdest[j] <= r_pdest[j-1];
        r_pval[j]  <= r_pval[j-1];
      end
    end
  end

  // Status pulses for the cycle after the issue/dispatch decision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_issue_error <= 1'b0;
      r_rs_issued   <= 6'd0;
      r_rs_exec     <= 6'd0;
    end else begin
      r_issue_error <= w_issue_err;
      r_rs_issued   <= w_issue_ok ? w_free_tag : 6'd0;
      r_rs_exec     <= w_disp_found ? w_disp_tag : 6'd0;
    end
  end

  assign issue_error        = r_issue_error;
  assign adder_available    = w_free_found;
  assign adder_RS_available = w_free_tag;
  assign RS_issued          = r_rs_issued;
  assign RS_executing_adder = r_rs_exec;
  assign RS_finished        = w_bc_tag;
  assign adder_rts          = w_bc_valid;
  assign result_value       = w_bc_value;
  assign result_dest        = w_bc_dest;

endmodule

// File: tb/tb_adder_reservation_stations.sv
// tb/tb_adder_reservation_stations.sv - randomized self-checking bench for adder_reservation_stations
module tb_adder_reservation_stations;

  localparam int NUM_RS = 3;
  localparam int L      = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue = 1'b0;
  logic [5:0]  operation = 6'd0;
  logic [2:0]  execution_unit = 3'd0;
  logic [4:0]  Dest_address = 5'd0;
  logic [4:0]  A_address = 5'd0;
  logic [4:0]  B_address = 5'd0;
  logic        issue_error;
  logic        adder_available;
  logic [5:0]  adder_RS_available;
  logic [5:0]  RS_issued;
  logic [5:0]  RS_executing_adder;
  logic [5:0]  RS_finished;
  logic        adder_rts;
  logic [31:0] result_value;
  logic [4:0]  result_dest;

  adder_reservation_stations #(.NUM_RS(NUM_RS), .ADDER_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .issue(issue), .operation(operation),
    .execution_unit(execution_unit), .Dest_address(Dest_address),
    .A_address(A_address), .B_address(B_address), .issue_error(issue_error),
    .adder_available(adder_available), .adder_RS_available(adder_RS_available),
    .RS_issued(RS_issued), .RS_executing_adder(RS_executing_adder),
    .RS_finished(RS_finished), .adder_rts(adder_rts), .result_value(result_value),
    .result_dest(result_dest)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: stations as records, results as a list of timed completions.
  typedef struct {
    int          due;
    int          tag;
    int          dest;
    logic [31:0] val;
  } res_t;

  logic [31:0] m_regs [32];
  int          m_status [32];
  bit          m_busy [NUM_RS];
  bit          m_exec [NUM_RS];
  int          m_func [NUM_RS];
  int          m_dest [NUM_RS];
  logic [31:0] m_vj [NUM_RS];
  logic [31:0] m_vk [NUM_RS];
  int          m_qj [NUM_RS];
  int          m_qk [NUM_RS];
  res_t        m_pend [$];
  int          m_cyc;
  bit          e_issue_error;
  int          e_rs_issued;
  int          e_rs_exec;

  function automatic logic [31:0] ref_alu(input int f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      0: return a + b;
      1: return a - b;
      4: return a | b;
      5: return a & b;
      6: return ~a;
      7: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i]   = 32'(i);
      m_status[i] = 0;
    end
    for (int i = 0; i < NUM_RS; i++) begin
      m_busy[i] = 0; m_exec[i] = 0; m_func[i] = 0; m_dest[i] = 0;
      m_vj[i] = 0; m_vk[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
    end
    m_pend.delete();
    m_cyc = 0;
    e_issue_error = 0;
    e_rs_issued = 0;
    e_rs_exec = 0;
  endtask

  task automatic model_edge(input bit iss, input logic [5:0] op, input logic [2:0] eu,
                            input int d, input int a, input int b);
    int bi, free_t, disp_t, qa, qb, ti;
    bit ok;
    logic [31:0] va, vb;
    res_t bc, nr;
    bi = -1;
    foreach (m_pend[k]) if (m_pend[k].due == m_cyc) bi = k;
    free_t = 0;
    for (int i = NUM_RS - 1; i >= 0; i--) if (!m_busy[i]) free_t = i + 1;
    disp_t = 0;
    for (int i = NUM_RS - 1; i >= 0; i--)
      if (m_busy[i] && !m_exec[i] && m_qj[i] == 0 && m_qk[i] == 0) disp_t = i + 1;
    ok = iss && eu == 3'b000 && free_t != 0;
    qa = m_status[a]; va = 0;
    if (qa == 0) va = m_regs[a];
    else if (bi >= 0 && m_pend[bi].tag == qa) begin va = m_pend[bi].val; qa = 0; end
    qb = m_status[b]; vb = 0;
    if (qb == 0) vb = m_regs[b];
    else if (bi >= 0 && m_pend[bi].tag == qb) begin vb = m_pend[bi].val; qb = 0; end
    if (bi >= 0) begin
      bc = m_pend[bi];
      m_regs[bc.dest] = bc.val;
      if (m_status[bc.dest] == bc.tag) m_status[bc.dest] = 0;
      m_busy[bc.tag-1] = 0;
      m_exec[bc.tag-1] = 0;
      for (int i = 0; i < NUM_RS; i++) begin
        if (m_busy[i] && m_qj[i] == bc.tag) begin m_vj[i] = bc.val; m_qj[i] = 0; end
        if (m_busy[i] && m_qk[i] == bc.tag) begin m_vk[i] = bc.val; m_qk[i] = 0; end
      end
      m_pend.delete(bi);
    end
    if (disp_t != 0) begin
      ti = disp_t - 1;
      m_exec[ti] = 1;
      nr.due = m_cyc + 1 + L;
      nr.tag = disp_t;
      nr.dest = m_dest[ti];
      nr.val = ref_alu(m_func[ti], m_vj[ti], m_vk[ti]);
      m_pend.push_back(nr);
    end
    if (ok) begin
      ti = free_t - 1;
      m_busy[ti] = 1; m_exec[ti] = 0;
      m_func[ti] = int'(op[2:0]); m_dest[ti] = d;
      m_vj[ti] = va; m_qj[ti] = qa; m_vk[ti] = vb; m_qk[ti] = qb;
      m_status[d] = free_t;
    end
    e_issue_error = iss && !ok;
    e_rs_issued = ok ? free_t : 0;
    e_rs_exec = disp_t;
    m_cyc++;
  endtask

  task automatic compare_all();
    int bi, free_t;
    logic [31:0] ev, ed, et;
    bi = -1;
    foreach (m_pend[k]) if (m_pend[k].due == m_cyc) bi = k;
    free_t = 0;
    for (int i = NUM_RS - 1; i >= 0; i--) if (!m_busy[i]) free_t = i + 1;
    ev = 0; ed = 0; et = 0;
    if (bi >= 0) begin
      ev = m_pend[bi].val; ed = 32'(m_pend[bi].dest); et = 32'(m_pend[bi].tag);
    end
    check("issue_error", 32'(issue_error), 32'(e_issue_error));
    check("adder_available", 32'(adder_available), 32'(free_t != 0));
    check("adder_RS_available", 32'(adder_RS_available), 32'(free_t));
    check("RS_issued", 32'(RS_issued), 32'(e_rs_issued));
    check("RS_executing_adder", 32'(RS_executing_adder), 32'(e_rs_exec));
    check("adder_rts", 32'(adder_rts), 32'(bi >= 0));
    check("result_value", result_value, ev);
    check("result_dest", 32'(result_dest), ed);
    check("RS_finished", 32'(RS_finished), et);
  endtask

  task automatic step(input bit iss, input logic [5:0] op, input logic [2:0] eu,
                      input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    issue = iss; operation = op; execution_unit = eu;
    Dest_address = d; A_address = a; B_address = b;
    @(posedge clock);
    model_edge(iss, op, eu, int'(d), int'(a), int'(b));
    #1;
    issue = 1'b0;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 3'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    issue = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [4:0] dest, input logic [31:0] exp);
    bit seen;
    seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      if (adder_rts && result_dest == dest) begin
        seen = 1;
        check(tag, result_value, exp);
      end else begin
        idle();
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rts_seen;
    do_reset();

    // Single add R1+R4 => R2
    step(1'b1, 6'd0, 3'd0, 5'd2, 5'd1, 5'd4);
    check("basic_issued", 32'(RS_issued), 32'd1);
    idle();
    check("basic_exec", 32'(RS_executing_adder), 32'd1);
    idle();
    idle();
    check("basic_rts", 32'(adder_rts), 32'd1);
    check("basic_value", result_value, 32'd5);
    check("basic_dest", 32'(result_dest), 32'd2);
    check("basic_finished", 32'(RS_finished), 32'd1);
    for (int n = 0; n < 4; n++) idle();

    // Dependent chain with forwarding
    do_reset();
    step(1'b1, 6'd0, 3'd0, 5'd2, 5'd1, 5'd4);
    step(1'b1, 6'd0, 3'd0, 5'd3, 5'd2, 5'd7);
    wait_result("chain_r3", 5'd3, 32'd12);
    idle();
    step(1'b1, 6'd0, 3'd0, 5'd4, 5'd2, 5'd0);
    wait_result("chain_r2_after", 5'd4, 32'd5);

    // Station exhaustion
    do_reset();
    step(1'b1, 6'd0, 3'd0, 5'd5, 5'd1, 5'd1);
    step(1'b1, 6'd1, 3'd0, 5'd6, 5'd9, 5'd3);
    step(1'b1, 6'd7, 3'd0, 5'd8, 5'd6, 5'd3);
    step(1'b1, 6'd0, 3'd0, 5'd9, 5'd1, 5'd2);
    check("full_issue_error", 32'(issue_error), 32'd1);
    check("full_rs_issued", 32'(RS_issued), 32'd0);
    check("full_available", 32'(adder_available), 32'd0);
    check("full_rs_available", 32'(adder_RS_available), 32'd0);
    for (int n = 0; n < 8; n++) idle();

    // Non-adder target unit
    do_reset();
    step(1'b1, 6'd0, 3'b001, 5'd5, 5'd1, 5'd2);
    check("wrong_unit_error", 32'(issue_error), 32'd1);
    check("wrong_unit_issued", 32'(RS_issued), 32'd0);
    check("wrong_unit_free", 32'(adder_RS_available), 32'd1);
    idle();
    check("wrong_unit_error_drop", 32'(issue_error), 32'd0);
    check("wrong_unit_no_exec", 32'(RS_executing_adder), 32'd0);

    // WAW on R2: the later writer keeps ownership
    do_reset();
    step(1'b1, 6'd0, 3'd0, 5'd2, 5'd1, 5'd4);
    step(1'b1, 6'd0, 3'd0, 5'd2, 5'd3, 5'd3);
    step(1'b1, 6'd0, 3'd0, 5'd6, 5'd2, 5'd0);
    wait_result("waw_reader", 5'd6, 32'd6);
    idle();
    step(1'b1, 6'd0, 3'd0, 5'd7, 5'd2, 5'd0);
    wait_result("waw_after", 5'd7, 32'd6);

    // Reset with two results in flight
    do_reset();
    step(1'b1, 6'd0, 3'd0, 5'd2, 5'd1, 5'd4);
    step(1'b1, 6'd0, 3'd0, 5'd5, 5'd3, 5'd3);
    idle();
    do_reset();
    check("midreset_available", 32'(adder_available), 32'd1);
    check("midreset_rs_available", 32'(adder_RS_available), 32'd1);
    rts_seen = 0;
    for (int n = 0; n < 6; n++) begin
      idle();
      if (adder_rts) rts_seen++;
    end
    check("midreset_no_rts", 32'(rts_seen), 32'd0);
    step(1'b1, 6'd0, 3'd0, 5'd1, 5'd2, 5'd0);
    wait_result("midreset_r2", 5'd1, 32'd2);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 9) < 6),
             6'($urandom_range(0, 63)),
             ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
             5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)));
      end
    end
    for (int n = 0; n < 20; n++) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_reservation_stations.md
ADDER_RESERVATION_STATIONS -- requirements
Module: adder_reservation_stations

Interface
REQ-001 SHALL have parameter NUM_RS, default 3, meaning the number of adder reservation stations, with tags 1..NUM_RS and tag 0 meaning none.
REQ-002 SHALL have parameter ADDER_LATENCY, default 2, meaning the number of cycles from dispatch to result.
REQ-003 clock  in  1  rising-edge clock; the block has this one clock only.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 issue  in  1  issue request from the instruction queue.
REQ-006 operation  in  6  opcode; bits [2:0] are the ALU function.
REQ-007 execution_unit  in  3  target unit; 3'b000 means adder.
REQ-008 Dest_address  in  5  destination register.
REQ-009 A_address  in  5  source register A.
REQ-010 B_address  in  5  source register B.
REQ-011 issue_error  out  1  one-cycle pulse when an issue is rejected.
REQ-012 adder_available  out  1  at least one reservation station is free.
REQ-013 adder_RS_available  out  6  tag of the lowest-index free station, or 0 if none.
REQ-014 RS_issued  out  6  one-cycle pulse carrying the tag just allocated.
REQ-015 RS_executing_adder  out  6  one-cycle pulse carrying the tag just dispatched.
REQ-016 RS_finished  out  6  one-cycle pulse carrying the tag whose result is on the bus.
REQ-017 adder_rts  out  1  result bus valid.
REQ-018 result_value  out  32  result bus data.
REQ-019 result_dest  out  5  result bus destination register.

Function
REQ-020 SHALL hold internal state: a 32x32 register file, a 32-entry register-status table of 6-bit tags, and per-station busy, func, dest, Vj, Qj, Vk, Qk and executing fields.
REQ-021 SHALL drive adder_available and adder_RS_available combinationally from current station state only, so a station freed this cycle is not offered until the next cycle.
REQ-022 SHALL, on a clock edge with issue=1, execution_unit=000 and a free station, allocate the station named by adder_RS_available and pulse RS_issued=tag in the following cycle.
REQ-023 SHALL, on allocation, capture each operand from the register file when its status entry is 0; otherwise it captures the status tag into Qj or Qk.
REQ-024 SHALL, when a result broadcast in the same cycle matches a source tag, capture the broadcast value instead (forwarding).
REQ-025 SHALL read sources before marking the destination, then set status[Dest_address]=tag; for example, A_address=Dest_address reads the old mapping.
REQ-026 SHALL, when issue=1 and either no station is free or execution_unit!=000, allocate nothing and pulse issue_error=1 for one cycle.
REQ-027 SHALL, each cycle, dispatch the lowest-index busy, non-executing station with Qj=Qk=0 into the fully pipelined adder and pulse RS_executing_adder=tag; at most one dispatch per cycle, and never in the allocation cycle.
REQ-028 SHALL compute func 000 A+B, 001 A-B, 100 A|B, 101 A&B, 110 ~A, 111 A^B, and 010/011 give 0; all arithmetic is modulo 2^32 with no carry or overflow output.
REQ-029 SHALL present each result ADDER_LATENCY cycles after dispatch as a one-cycle event: adder_rts=1, result_value, result_dest and RS_finished=tag.
REQ-030 SHALL, on that result event, free the station, resolve matching Qj/Qk in all waiting stations, write the register file, and clear the status entry only if status[dest] still equals the tag (a WAW later writer keeps ownership).
REQ-031 SHALL hold all outputs other than adder_available and adder_RS_available at 0 when not pulsing.

Reset
REQ-032 SHALL, on reset=1 at any time including mid-operation, immediately clear all stations, the pipeline and the status table, set register R[i]=i, and drive all outputs to 0 except adder_available=1 and adder_RS_available=1.
REQ-033 SHALL discard in-flight results on reset and produce no RS_finished for them.

Verification
REQ-034 Reset, then issue add R1+R4 => R2 -> RS_issued=1 at T+1, RS_executing_adder=1 at T+2, adder_rts=1 with result_value=5, result_dest=2, RS_finished=1 at T+4.
REQ-035 Back-to-back R1+R4 => R2 then R2+R7 => R3 -> second station waits on tag 1 and receives the forwarded 5; result R3=12; R2 status cleared.
REQ-036 Four adder issues with no completions -> the fourth gives issue_error=1, adder_available=0, adder_RS_available=0, and no RS_issued.
REQ-037 Issue with execution_unit=001 -> issue_error=1 for one cycle and no state change.
REQ-038 Two writers to R2 in flight -> only the later tag's completion clears status[2]; a third instruction reading R2 gets the later value.
REQ-039 Assert reset while two results are in the pipeline -> no adder_rts afterward, all stations free, and R2 reads 2.
